mgmt_gpio_ctrl: RTL and testbench

Wishbone-slave controller for the single management GPIO pad (`gpio_out_pad`) of the management SoC. It provides manual drive, output-enable and input sampling. It also contains a hardware blink sequencer that emits a programmed number of high/low pulses of programmed half-period, so firmware can drive LED/heartbeat patterns without polling. It sits on the mgmt core Wishbone bus alongside the housekeeping and user-project slaves.

---
 rtl/mgmt_gpio_pkg.sv | 37 +++
 rtl/mgmt_gpio_blinker.sv | 96 +++++++++
 rtl/mgmt_gpio_ctrl.sv | 141 ++++++++++++++
 tb/tb_mgmt_gpio_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_gpio_pkg.sv
// Shared definitions for the management GPIO controller: register offsets,
// CTRL/STATUS bit positions, blink sequencer state encoding and a helper
// that expands Wishbone byte selects into a bit mask.
package mgmt_gpio_pkg;

  // Register offsets, as seen on wb_adr_i[3:2]
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PERIOD = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // CTRL bit positions
  localparam int CTRL_OUT_VAL = 0;
  localparam int CTRL_OEB     = 1;
  localparam int CTRL_START   = 2;
  localparam int CTRL_IRQ_EN  = 3;
  localparam int CTRL_STOP    = 4;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_IN_SYNC = 2;
  localparam int STAT_REM_LSB = 16;

  // Blink sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } blink_state_e;

  // One mask bit per data bit, set where the matching byte lane is selected
  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/mgmt_gpio_blinker.sv
// Blink sequencer: emits high/low pulses of a programmable half-period,
// a programmable number of times (0 = run until stopped).
module mgmt_gpio_blinker
  import mgmt_gpio_pkg::*;
#(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] period,
  input  logic [15:0]         count,
  output logic                busy,
  output logic                level,
  output logic [15:0]         remaining,
  output logic                done_pulse
);

  localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);

  blink_state_e        state;
  logic [PERIOD_W-1:0] half_cnt;
  logic [PERIOD_W-1:0] reload;
  logic                continuous;
  logic                expire;
  logic                last_pulse;

  // Reload value, counter expiry and end-of-sequence detection
  always_comb begin
    // NOTE: every always_comb output gets a value on every path; a missed
    // branch would otherwise infer a latch.
    reload     = (period == '0) ? ONE_P : period;
    expire     = (half_cnt == ONE_P);
    last_pulse = (state == ST_LOW) && expire && !continuous && (remaining == 16'd1);
    // A simultaneous start or stop overrides a natural finish
    done_pulse = last_pulse && !start && !stop;
  end

  // Sequencer FSM with registered busy/level outputs; stop beats start
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    if (rst) begin
      state      <= ST_IDLE;
      half_cnt   <= '0;
      remaining  <= '0;
      continuous <= 1'b0;
      busy       <= 1'b0;
      level      <= 1'b0;
    end else if (stop) begin
      state    <= ST_IDLE;
      half_cnt <= '0;
      busy     <= 1'b0;
      level    <= 1'b0;
    end else if (start) begin
      state      <= ST_HIGH;
      half_cnt   <= reload;
      remaining  <= count;
      continuous <= (count == 16'd0);
      busy       <= 1'b1;
      level      <= 1'b1;
    end else begin
      case (state)
        ST_HIGH: begin
          if (expire) begin
            state    <= ST_LOW;
            level    <= 1'b0;
            half_cnt <= reload;
          end else begin
            half_cnt <= half_cnt - ONE_P;
          end
        end
        ST_LOW: begin
          if (expire) begin
            if (last_pulse) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              remaining <= '0;
              half_cnt  <= '0;
            end else begin
              state    <= ST_HIGH;
              level    <= 1'b1;
              half_cnt <= reload;
              if (!continuous) remaining <= remaining - 16'd1;
            end
          end else begin
            half_cnt <= half_cnt - ONE_P;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mgmt_gpio_ctrl.sv
// Wishbone slave for the management GPIO pad: manual drive, output enable,
// synchronized input sampling and a hardware blink sequencer.
// Build option: define MGMT_GPIO_IRQ_EN to make CTRL.irq_en writable and
// drive gpio_irq = done & irq_en; otherwise gpio_irq is tied low.
module mgmt_gpio_ctrl
  import mgmt_gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h2600_0000,
  parameter int          PERIOD_W = 24
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        gpio_in_pad,
  output logic        gpio_out_pad,
  output logic        gpio_oeb_pad,
  output logic        gpio_irq
);

  logic                req, wr, wr_ctrl, done_w1c;
  logic [1:0]          offset;
  logic [31:0]         lane_mask, rd_data;
  logic                out_val, oeb, irq_en, done;
  logic [PERIOD_W-1:0] period;
  logic [15:0]         count;
  logic                in_meta, in_sync;
  logic                busy, level, done_pulse;
  logic [15:0]         remaining;
  logic                unused_ok;

  // A new request is accepted only while no ack is outstanding
  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o & (wb_adr_i[31:4] == BASE_ADR[31:4]);
  assign wr        = req & wb_we_i;
  assign offset    = wb_adr_i[3:2];
  assign lane_mask = sel_mask(wb_sel_i);
  assign wr_ctrl   = wr && (offset == OFF_CTRL) && wb_sel_i[0];
  assign done_w1c  = wr && (offset == OFF_STATUS) && wb_sel_i[0] && wb_dat_i[STAT_DONE];
  assign unused_ok = &{1'b0, wb_adr_i[1:0], wb_dat_i, lane_mask};

  mgmt_gpio_blinker #(.PERIOD_W(PERIOD_W)) u_blinker (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .start      (wr_ctrl & wb_dat_i[CTRL_START]),
    .stop       (wr_ctrl & wb_dat_i[CTRL_STOP]),
    .period     (period),
    .count      (count),
    .busy       (busy),
    .level      (level),
    .remaining  (remaining),
    .done_pulse (done_pulse)
  );

  // Software-visible registers; a completing sequence sets done ahead of a W1C
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_val <= 1'b0;
      oeb     <= 1'b1;
      period  <= PERIOD_W'(1);
      count   <= '0;
      done    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        out_val <= wb_dat_i[CTRL_OUT_VAL];
        oeb     <= wb_dat_i[CTRL_OEB];
      end
      if (wr && offset == OFF_PERIOD)
        period <= (period & ~lane_mask[PERIOD_W-1:0]) | (wb_dat_i[PERIOD_W-1:0] & lane_mask[PERIOD_W-1:0]);
      if (wr && offset == OFF_COUNT)
        count <= (count & ~lane_mask[15:0]) | (wb_dat_i[15:0] & lane_mask[15:0]);
      if (done_pulse)    done <= 1'b1;
      else if (done_w1c) done <= 1'b0;
    end
  end

`ifdef MGMT_GPIO_IRQ_EN
  // Interrupt enable exists only when the interrupt is built in
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)     irq_en <= 1'b0;
    else if (wr_ctrl) irq_en <= wb_dat_i[CTRL_IRQ_EN];
  end
  assign gpio_irq = done & irq_en;
`else
  assign irq_en   = 1'b0;
  assign gpio_irq = 1'b0;
`endif

  // Two-flop synchronizer for the asynchronous pad input
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      in_meta <= 1'b0;
      in_sync <= 1'b0;
    end else begin
      in_meta <= gpio_in_pad;
      in_sync <= in_meta;
    end
  end

  // Read-data mux; write-only bits and unused fields read as zero
  always_comb begin
    rd_data = '0;
    case (offset)
      OFF_CTRL: begin
        rd_data[CTRL_OUT_VAL] = out_val;
        rd_data[CTRL_OEB]     = oeb;
        rd_data[CTRL_IRQ_EN]  = irq_en;
      end
      OFF_PERIOD: rd_data[PERIOD_W-1:0] = period;
      OFF_COUNT:  rd_data[15:0]         = count;
      OFF_STATUS: begin
        rd_data[STAT_BUSY]              = busy;
        rd_data[STAT_DONE]              = done;
        rd_data[STAT_IN_SYNC]           = in_sync;
        rd_data[STAT_REM_LSB +: 16]     = remaining;
      end
      default: ;
    endcase
  end

  // Single-cycle ack with registered read data; reset drops a pending ack
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      if (req) wb_dat_o <= rd_data;
    end
  end

  // The sequencer owns the pad while busy and always drives it
  assign gpio_out_pad = busy ? level : out_val;
  assign gpio_oeb_pad = busy ? 1'b0 : oeb;

endmodule

// File: tb/tb_mgmt_gpio_ctrl.sv
// Self-checking bench for mgmt_gpio_ctrl: bus reads and per-cycle pad
// expectations are queued by the stimulus and consumed by a monitor.
module tb_mgmt_gpio_ctrl;

  localparam logic [31:0] BASE = 32'h2600_0000;

`ifdef MGMT_GPIO_IRQ_EN
  localparam bit IRQ_BUILT = 1'b1;
`else
  localparam bit IRQ_BUILT = 1'b0;
`endif

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        gpio_in_pad = 1'b0;
  logic        gpio_out_pad, gpio_oeb_pad, gpio_irq;

  mgmt_gpio_ctrl dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .wb_cyc_i     (wb_cyc_i),
    .wb_stb_i     (wb_stb_i),
    .wb_we_i      (wb_we_i),
    .wb_sel_i     (wb_sel_i),
    .wb_adr_i     (wb_adr_i),
    .wb_dat_i     (wb_dat_i),
    .wb_dat_o     (wb_dat_o),
    .wb_ack_o     (wb_ack_o),
    .gpio_in_pad  (gpio_in_pad),
    .gpio_out_pad (gpio_out_pad),
    .gpio_oeb_pad (gpio_oeb_pad),
    .gpio_irq     (gpio_irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    logic [31:0] mask;
    string       name;
  } bus_exp_t;

  typedef struct {
    logic out_v;
    logic oeb_v;
    logic irq_v;
  } pad_exp_t;

  bus_exp_t bus_q[$];
  pad_exp_t pad_q[$];
  int       checks = 0;
  int       errors = 0;
  bit       prev_ack = 1'b0;

  // Reference model state
  bit          m_out = 0, m_oeb = 1, m_irq_en = 0, m_done = 0, m_in = 0;
  logic [23:0] m_period = 24'd1;
  logic [15:0] m_count  = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic bit exp_irq();
    return IRQ_BUILT & m_irq_en & m_done;
  endfunction

  function automatic logic [31:0] exp_ctrl();
    logic [31:0] v;
    v    = '0;
    v[0] = m_out;
    v[1] = m_oeb;
    v[3] = IRQ_BUILT & m_irq_en;
    return v;
  endfunction

  // Monitor: consumes queued expectations, away from the active edge
  bus_exp_t mon_e;
  pad_exp_t mon_p;
  always @(negedge wb_clk_i) begin
    #1;
    if (wb_ack_o) begin
      check("ack_single_cycle", {31'b0, prev_ack}, 32'd0);
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ack: got ack expected none");
      end else begin
        mon_e = bus_q.pop_front();
        if (mon_e.is_read) check(mon_e.name, wb_dat_o & mon_e.mask, mon_e.data & mon_e.mask);
      end
    end
    prev_ack = wb_ack_o;
    if (pad_q.size() > 0) begin
      mon_p = pad_q.pop_front();
      check("pad_out", {31'b0, gpio_out_pad}, {31'b0, mon_p.out_v});
      check("pad_oeb", {31'b0, gpio_oeb_pad}, {31'b0, mon_p.oeb_v});
      check("pad_irq", {31'b0, gpio_irq},     {31'b0, mon_p.irq_v});
    end
  end

  task automatic wb_xfer(input bit w, input logic [1:0] off, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp_d,
                         input logic [31:0] m, input string name);
    bus_exp_t e;
    bit       got;
    @(negedge wb_clk_i);
    e.is_read = !w;
    e.data    = exp_d;
    e.mask    = m;
    e.name    = name;
    bus_q.push_back(e);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = w;
    wb_adr_i = BASE | {28'b0, off, 2'b00};
    wb_dat_i = d;
    wb_sel_i = s;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge wb_clk_i);
      got = wb_ack_o;
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_ack_timeout: got no ack expected ack within 8 cycles", name);
      void'(bus_q.pop_back());
    end
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d, input logic [3:0] s);
    wb_xfer(1'b1, off, d, s, 32'h0, 32'h0, "write");
  endtask

  task automatic rd(input logic [1:0] off, input logic [31:0] exp_d, input logic [31:0] m,
                    input string name);
    wb_xfer(1'b0, off, 32'h0, 4'hF, exp_d, m, name);
  endtask

  // Pad expectations while the pad is under manual control
  task automatic push_static(input int n);
    pad_exp_t p;
    for (int k = 0; k < n; k++) begin
      p.out_v = m_out;
      p.oeb_v = m_oeb;
      p.irq_v = exp_irq();
      pad_q.push_back(p);
    end
  endtask

  // Pad waveform for a sequence started at the edge just observed (k = 0)
  task automatic push_blink(input int per, input int n, input int len);
    pad_exp_t p;
    int       pe;
    bit       in_seq;
    pe = (per == 0) ? 1 : per;
    for (int k = 0; k < len; k++) begin
      in_seq = (n == 0) || (k < 2 * pe * n);
      if (!in_seq) m_done = 1'b1;
      p.out_v = in_seq ? (((k / pe) % 2) == 0) : m_out;
      p.oeb_v = in_seq ? 1'b0 : m_oeb;
      p.irq_v = exp_irq();
      pad_q.push_back(p);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_oeb = 1; m_irq_en = 0; m_done = 0;
    m_period = 24'd1; m_count = 16'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  s;
    int          per, n, len;
    logic [31:0] ctrl;

    // Reset and read every register
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    model_reset();
    push_static(2);
    rd(OFF(0), 32'h0000_0002, 32'hFFFF_FFFF, "rst_ctrl");
    rd(OFF(1), 32'h0000_0001, 32'hFFFF_FFFF, "rst_period");
    rd(OFF(2), 32'h0000_0000, 32'hFFFF_FFFF, "rst_count");
    rd(OFF(3), 32'h0000_0000, 32'hFFFF_FFFF, "rst_status");

    // Manual drive
    wr(OFF(0), 32'h1, 4'hF);
    m_out = 1; m_oeb = 0;
    push_static(2);
    rd(OFF(0), exp_ctrl(), 32'hFFFF_FFFF, "manual_ctrl");

    // Byte-lane writes to PERIOD and COUNT
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      wr(OFF(1), d, s);
      m_period = 24'(merge({8'h0, m_period}, d, s));
      rd(OFF(1), {8'h0, m_period}, 32'hFFFF_FFFF, "period_lanes");
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      wr(OFF(2), d, s);
      m_count = 16'(merge({16'h0, m_count}, d, s));
      rd(OFF(2), {16'h0, m_count}, 32'hFFFF_FFFF, "count_lanes");
    end

    // Counted blink sequences; the first one is PERIOD=5, COUNT=3 with irq_en
    for (int it = 0; it < 5; it++) begin
      per      = (it == 0) ? 5 : $urandom_range(0, 4);
      n        = (it == 0) ? 3 : $urandom_range(1, 3);
      m_out    = 1'($urandom);
      m_oeb    = 1'($urandom);
      m_irq_en = (it == 0) ? 1'b1 : 1'($urandom);
      m_in     = 1'($urandom);
      gpio_in_pad = m_in;
      wr(OFF(1), 32'(per), 4'hF);
      m_period = 24'(per);
      wr(OFF(2), 32'(n), 4'hF);
      m_count = 16'(n);
      wr(OFF(3), 32'h2, 4'hF);
      m_done = 0;
      ctrl = {27'b0, 1'b0, m_irq_en, 1'b1, m_oeb, m_out};
      wr(OFF(0), ctrl, 4'hF);
      len = 2 * ((per == 0) ? 1 : per) * n + 3;
      push_blink(per, n, len);
      repeat (len) @(negedge wb_clk_i);
      rd(OFF(3), {29'b0, m_in, m_done, 1'b0}, 32'h0000_0007, "blink_status_done");
      rd(OFF(0), exp_ctrl(), 32'hFFFF_FFFF, "blink_ctrl");
      wr(OFF(3), 32'h2, 4'h1);
      m_done = 0;
      push_static(2);
      rd(OFF(3), {29'b0, m_in, 2'b00}, 32'h0000_0007, "w1c_status");
    end

    // Continuous toggle, then stop (start also set: stop wins)
    m_out = 1; m_oeb = 1; m_irq_en = 1;
    wr(OFF(1), 32'h0, 4'hF);
    m_period = 24'h0;
    wr(OFF(2), 32'h0, 4'hF);
    m_count = 16'h0;
    wr(OFF(0), 32'h0000_000F, 4'hF);
    push_blink(0, 0, 7);
    repeat (7) @(negedge wb_clk_i);
    wr(OFF(0), 32'h0000_001F, 4'hF);
    push_static(3);
    rd(OFF(3), {16'h0, 13'b0, m_in, 2'b00}, 32'hFFFF_FFFF, "stop_status");

    // Input synchronizer follows the pad
    m_in = ~m_in;
    gpio_in_pad = m_in;
    repeat (3) @(negedge wb_clk_i);
    rd(OFF(3), {29'b0, m_in, 2'b00}, 32'h0000_0004, "in_sync");

    // Reset in the middle of the second pulse, with a request pending
    m_out = 1'($urandom); m_oeb = 1'($urandom);
    wr(OFF(1), 32'd10, 4'hF);
    wr(OFF(2), 32'd4, 4'hF);
    wr(OFF(0), {29'b0, 1'b1, m_oeb, m_out}, 4'hF);
    m_irq_en = 0;
    push_blink(10, 4, 25);
    repeat (25) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_adr_i = BASE | 32'hC;
    @(negedge wb_clk_i);
    model_reset();
    push_static(1);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    rd(OFF(0), 32'h0000_0002, 32'hFFFF_FFFF, "post_rst_ctrl");
    rd(OFF(1), 32'h0000_0001, 32'hFFFF_FFFF, "post_rst_period");
    rd(OFF(2), 32'h0000_0000, 32'hFFFF_FFFF, "post_rst_count");
    rd(OFF(3), {29'b0, m_in, 2'b00}, 32'hFFFF_FFFF, "post_rst_status");

    repeat (3) @(negedge wb_clk_i);
    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    check("pad_queue_drained", 32'(pad_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [1:0] OFF(input int i);
    return 2'(i);
  endfunction

endmodule
